// File: rtl/vldu_lane_writer_if.sv
// Load-writeback bus bundle: descriptor in, memory beats in, VRF write port out, done pulse out.
// Latency: none; wires only.
// Backpressure: req_rdy / mem_rdy stall the producers, load_op_gnt stalls the FIFO head.
//
// Ports (slave = the lane writer, master = its environment):
//   req_*      load descriptor handshake and fields
//   mem_*      raw memory beat handshake and data
//   load_op_*  VRF write request toward the lane's arbiter, load_id is the head beat's id
//   done*      one-cycle completion pulse and its instruction id
interface vldu_lane_writer_if #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned IdWidth   = 2,
    parameter int unsigned CntWidth  = 8
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned LbWidth   = $clog2(StrbWidth);

    logic                 req_vld;
    logic                 req_rdy;
    logic [AddrWidth-1:0] req_addr;
    logic [CntWidth-1:0]  req_beats;
    logic [LbWidth-1:0]   req_last_bytes;
    logic [IdWidth-1:0]   req_id;

    logic                 mem_vld;
    logic                 mem_rdy;
    logic [DataWidth-1:0] mem_dat;

    logic                 load_op_vld;
    logic                 load_op_gnt;
    logic [DataWidth-1:0] load_op_dat;
    logic [StrbWidth-1:0] load_op_strb;
    logic [AddrWidth-1:0] load_op_addr;
    logic [IdWidth-1:0]   load_id;

    logic                 done;
    logic [IdWidth-1:0]   done_id;

    modport master (
        output req_vld, req_addr, req_beats, req_last_bytes, req_id,
        input  req_rdy,
        output mem_vld, mem_dat,
        input  mem_rdy,
        input  load_op_vld, load_op_dat, load_op_strb, load_op_addr, load_id,
        output load_op_gnt,
        input  done, done_id
    );

    modport slave (
        input  req_vld, req_addr, req_beats, req_last_bytes, req_id,
        output req_rdy,
        input  mem_vld, mem_dat,
        output mem_rdy,
        output load_op_vld, load_op_dat, load_op_strb, load_op_addr, load_id,
        input  load_op_gnt,
        output done, done_id
    );
endinterface

// File: rtl/vldu_lane_writer.sv
// Generic FIFO used for the lane writer's beat buffer.
// Latency: a push is visible at the head the following cycle; no fall-through.
// Backpressure: full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
//
// Ports: clk, rst (async, active-high), push/push_dat, pop, head, full, empty.
module vldu_lane_writer_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntW     = PtrWidth + 1;

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntW-1:0]     cnt;

    assign full  = (cnt == CntW'(Depth));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CntW'(push) - CntW'(pop);
        end
    end

    // Storage needs no reset: the consumer gates the head with empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assert property (@(posedge clk) disable iff (rst) push |-> !full);
    assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
endmodule

// Per-lane load writeback: tags memory beats with VRF address/strobe/id and buffers them for the VRF write port.
// Latency: beat accepted in cycle N is presented at load_op_* in N+1; done pulses the cycle after the last beat is granted.
// Backpressure: mem_rdy drops while the beat FIFO is full; req_rdy is low while a descriptor is being consumed.
//
// Ports: clk, rst (async, active-high), io (vldu_lane_writer_if.slave):
//   descriptor req_*, memory beats mem_*, VRF write port load_op_* / load_id / load_op_gnt, completion done / done_id.
module vldu_lane_writer #(
    parameter int unsigned LaneId    = 0,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned IdWidth   = 2,
    parameter int unsigned CntWidth  = 8,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                clk,
    input  logic                rst,
    vldu_lane_writer_if.slave   io
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned LbWidth   = $clog2(StrbWidth);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic                 last;
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [StrbWidth-1:0] strb;
        logic [DataWidth-1:0] dat;
    } beat_t;

    state_t               state;
    logic                 req_rdy_q;
    logic [AddrWidth-1:0] cur_addr;
    logic [CntWidth-1:0]  beats_q;
    logic [CntWidth-1:0]  beat_idx;
    logic [LbWidth-1:0]   last_bytes_q;
    logic [IdWidth-1:0]   id_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    beat_t                fifo_head;
    beat_t                push_beat;
    beat_t                head_q;
    logic                 mem_push;
    logic                 push_last;
    logic                 pop;
    logic [StrbWidth-1:0] last_mask;
    logic                 done_q;
    logic [IdWidth-1:0]   done_id_q;

    assign io.req_rdy = req_rdy_q;
    assign io.mem_rdy = (state == ACTIVE) && !fifo_full;
    assign mem_push   = io.mem_vld && io.mem_rdy;
    assign push_last  = (beat_idx == beats_q - CntWidth'(1));

    // Partial-beat strobe: low last_bytes lanes enabled; zero means the whole word.
    always_comb begin
        last_mask = '1;
        if (last_bytes_q != '0) begin
            for (int i = 0; i < StrbWidth; i++) begin
                last_mask[i] = (LbWidth'(i) < last_bytes_q);
            end
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.dat  = io.mem_dat;
        push_beat.strb = push_last ? last_mask : '1;
        push_beat.addr = cur_addr;
        push_beat.id   = id_q;
        push_beat.last = push_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_rdy_q    <= 1'b1;
            cur_addr     <= '0;
            beats_q      <= '0;
            beat_idx     <= '0;
            last_bytes_q <= '0;
            id_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Zero-beat descriptors are accepted and dropped here.
                    if (io.req_vld && req_rdy_q && io.req_beats != '0) begin
                        cur_addr     <= io.req_addr;
                        beats_q      <= io.req_beats;
                        beat_idx     <= '0;
                        last_bytes_q <= io.req_last_bytes;
                        id_q         <= io.req_id;
                        req_rdy_q    <= 1'b0;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (mem_push) begin
                        // Address wraps silently at 2^AddrWidth.
                        cur_addr <= cur_addr + 1'b1;
                        beat_idx <= beat_idx + 1'b1;
                        if (push_last) begin
                            req_rdy_q <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    req_rdy_q <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    vldu_lane_writer_fifo #(
        .Width ($bits(beat_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mem_push),
        .push_dat (push_beat),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head fields read as zero whenever nothing is buffered, including after reset.
    assign head_q = fifo_empty ? '0 : fifo_head;
    assign pop    = io.load_op_vld && io.load_op_gnt;

    assign io.load_op_vld  = !fifo_empty;
    assign io.load_op_dat  = head_q.dat;
    assign io.load_op_strb = head_q.strb;
    assign io.load_op_addr = head_q.addr;
    assign io.load_id      = head_q.id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            done_q <= pop && head_q.last;
            if (pop && head_q.last) done_id_q <= head_q.id;
        end
    end

    assign io.done    = done_q;
    assign io.done_id = done_id_q;

    assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> !mem_push)
        else $error("lane %0d: beat accepted while idle", LaneId);
    assert property (@(posedge clk) disable iff (rst)
        (io.load_op_vld && !io.load_op_gnt) |=> (io.load_op_vld && $stable(head_q)))
        else $error("lane %0d: head changed while stalled", LaneId);
endmodule

// File: tb/tb_vldu_lane_writer.sv
module tb_vldu_lane_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vldu_lane_writer_if #(.DataWidth(64), .AddrWidth(8), .IdWidth(2), .CntWidth(8)) bus ();

    vldu_lane_writer #(
        .LaneId(0), .DataWidth(64), .AddrWidth(8), .IdWidth(2), .CntWidth(8), .FifoDepth(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [63:0] dat;
        logic [7:0]  strb;
        logic [7:0]  addr;
        logic [1:0]  id;
        logic        last;
    } want_t;

    int          n_vec = 0;
    int          n_err = 0;
    want_t       want_q[$];
    logic        want_done;
    logic [1:0]  want_done_id;
    logic [7:0]  m_addr;
    logic [7:0]  m_beats;
    logic [7:0]  m_idx;
    logic [2:0]  m_lb;
    logic [1:0]  m_id;
    logic        req_fired;
    logic        mem_fired;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // One clock: check outputs against the scoreboard, model any handshakes, advance.
    task automatic cycle();
        want_t      e;
        logic       nd;
        logic [1:0] nid;
        #1;
        chk("done", bus.done, want_done);
        if (want_done) chk("done_id", bus.done_id, want_done_id);
        nd  = 1'b0;
        nid = 2'd0;
        if (bus.load_op_vld && bus.load_op_gnt) begin
            if (want_q.size() == 0) begin
                chk("unexpected_beat", bus.load_op_vld, 1'b0);
            end else begin
                e = want_q.pop_front();
                chk("wr_dat",  bus.load_op_dat,  e.dat);
                chk("wr_strb", bus.load_op_strb, e.strb);
                chk("wr_addr", bus.load_op_addr, e.addr);
                chk("wr_id",   bus.load_id,      e.id);
                if (e.last) begin
                    nd  = 1'b1;
                    nid = e.id;
                end
            end
        end
        req_fired = bus.req_vld && bus.req_rdy;
        if (req_fired && bus.req_beats != 8'd0) begin
            m_addr  = bus.req_addr;
            m_beats = bus.req_beats;
            m_lb    = bus.req_last_bytes;
            m_id    = bus.req_id;
            m_idx   = 8'd0;
        end
        mem_fired = bus.mem_vld && bus.mem_rdy;
        if (mem_fired) begin
            e.dat  = bus.mem_dat;
            e.last = (m_idx == m_beats - 8'd1);
            e.strb = (e.last && m_lb != 3'd0) ? (8'hFF >> (8 - m_lb)) : 8'hFF;
            e.addr = m_addr + m_idx;
            e.id   = m_id;
            want_q.push_back(e);
            m_idx  = m_idx + 8'd1;
        end
        @(posedge clk);
        @(negedge clk);
        want_done    = nd;
        want_done_id = nid;
    endtask

    task automatic send_req(input logic [7:0] addr, input logic [7:0] beats,
                            input logic [2:0] lb, input logic [1:0] id);
        logic fired;
        bus.req_vld        = 1'b1;
        bus.req_addr       = addr;
        bus.req_beats      = beats;
        bus.req_last_bytes = lb;
        bus.req_id         = id;
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            cycle();
            fired = req_fired;
        end
        bus.req_vld = 1'b0;
        chk("req_accept", fired, 1'b1);
    endtask

    task automatic send_beat(input logic [63:0] d);
        logic fired;
        bus.mem_vld = 1'b1;
        bus.mem_dat = d;
        fired = 1'b0;
        for (int i = 0; i < 60 && !fired; i++) begin
            cycle();
            fired = mem_fired;
        end
        bus.mem_vld = 1'b0;
        chk("beat_accept", fired, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (want_q.size() != 0 || want_done); i++) cycle();
        chk("drain_empty", want_q.size(), 0);
        cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, bus.req_rdy, 1'b1);
        chk({tag, "_mem_rdy"}, bus.mem_rdy, 1'b0);
        chk({tag, "_vld"},     bus.load_op_vld, 1'b0);
        chk({tag, "_done"},    bus.done, 1'b0);
        chk({tag, "_dat"},     bus.load_op_dat, 64'd0);
        chk({tag, "_strb"},    bus.load_op_strb, 8'd0);
        chk({tag, "_addr"},    bus.load_op_addr, 8'd0);
        chk({tag, "_id"},      bus.load_id, 2'd0);
        chk({tag, "_done_id"}, bus.done_id, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.req_vld        = 1'b0;
        bus.req_addr       = 8'd0;
        bus.req_beats      = 8'd0;
        bus.req_last_bytes = 3'd0;
        bus.req_id         = 2'd0;
        bus.mem_vld        = 1'b0;
        bus.mem_dat        = 64'd0;
        bus.load_op_gnt    = 1'b0;
        want_done          = 1'b0;
        want_done_id       = 2'd0;
        m_addr = 8'd0; m_beats = 8'd0; m_idx = 8'd0; m_lb = 3'd0; m_id = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        cycle();

        // Three back-to-back full beats with grant held high.
        bus.load_op_gnt = 1'b1;
        send_req(8'h10, 8'd3, 3'd0, 2'd1);
        chk("req_rdy_busy", bus.req_rdy, 1'b0);
        send_beat(64'hD0D0_0000_0000_00D0);
        send_beat(64'hD1D1_0000_0000_00D1);
        send_beat(64'hD2D2_0000_0000_00D2);
        drain();

        // Partial last beat: 3 valid bytes.
        send_req(8'h20, 8'd2, 3'd3, 2'd2);
        send_beat({$urandom, $urandom});
        send_beat({$urandom, $urandom});
        drain();

        // Backpressure: FIFO fills after four beats while grant is low.
        bus.load_op_gnt = 1'b0;
        send_req(8'h28, 8'd6, 3'd5, 2'd3);
        for (int b = 0; b < 4; b++) send_beat(64'h6000 + 64'(b));
        bus.mem_vld = 1'b1;
        bus.mem_dat = 64'h6004;
        cycle();
        chk("full_no_push", mem_fired, 1'b0);
        cycle();
        chk("full_mem_rdy", bus.mem_rdy, 1'b0);
        chk("full_head_id", bus.load_id, 2'd3);
        bus.load_op_gnt = 1'b1;
        send_beat(64'h6004);
        send_beat(64'h6005);
        drain();

        // Address wrap at the top of the VRF address space.
        send_req(8'hFE, 8'd4, 3'd0, 2'd0);
        for (int b = 0; b < 4; b++) send_beat({$urandom, $urandom});
        drain();

        // Two instructions queued behind a stalled head: done order id 0 then id 2.
        bus.load_op_gnt = 1'b0;
        send_req(8'h30, 8'd2, 3'd0, 2'd0);
        send_beat(64'hA0);
        send_beat(64'hA1);
        send_req(8'h40, 8'd1, 3'd2, 2'd2);
        send_beat(64'hB0);
        chk("mixed_head_id", bus.load_id, 2'd0);
        bus.load_op_gnt = 1'b1;
        drain();

        // Reset with two of four beats buffered.
        bus.load_op_gnt = 1'b0;
        send_req(8'h50, 8'd4, 3'd0, 2'd1);
        send_beat(64'hC0);
        send_beat(64'hC1);
        chk("pre_rst_vld", bus.load_op_vld, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        want_q.delete();
        want_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.load_op_gnt = 1'b1;
        repeat (3) cycle();
        send_req(8'h60, 8'd1, 3'd0, 2'd2);
        send_beat(64'hE0);
        drain();

        // Zero-beat descriptor is swallowed; stray memory valid is ignored in IDLE.
        send_req(8'h70, 8'd0, 3'd0, 2'd3);
        chk("zero_req_rdy", bus.req_rdy, 1'b1);
        bus.mem_vld = 1'b1;
        bus.mem_dat = 64'hBAD;
        cycle();
        cycle();
        chk("zero_no_push", mem_fired, 1'b0);
        chk("zero_no_out", bus.load_op_vld, 1'b0);
        bus.mem_vld = 1'b0;
        send_req(8'h71, 8'd2, 3'd1, 2'd3);
        send_beat(64'hF0);
        send_beat(64'hF1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
